// File: rtl/dmux_disp_pkg.sv
// Shared types and defaults for the 1:2 sequenced stream dispatcher.
package dmux_disp_pkg;

  typedef enum logic [1:0] {
    MODE_FIXED = 2'd0,
    MODE_RR    = 2'd1,
    MODE_FILL  = 2'd2
  } mode_e;

  localparam int WIDTH_DEF = 8;
  localparam int CNT_W_DEF = 16;

endpackage : dmux_disp_pkg

// File: rtl/dmux_disp_slot.sv
// One-entry valid/ready output register; the parent only asserts load
// when can_accept is high, so a stalled word is never overwritten.
module dmux_disp_slot #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic             can_accept
);

  // A slot being drained this cycle frees up in time to take a new word.
  assign can_accept = ~out_valid | out_ready;

  // NOTE: state uses non-blocking assignments; the data register is reset too,
  // because out_data is required to read zero after reset, not just be ignored.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (load) begin
      out_valid <= 1'b1;
      out_data  <= load_data;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule : dmux_disp_slot

// File: rtl/dmux_1by2_dispatcher.sv
// Sequenced 1:2 dispatcher: policy-driven target select, two output slots,
// per-channel wrapping dispatch counters and a round-robin pointer.
module dmux_1by2_dispatcher
  import dmux_disp_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       mode,
  input  logic             sel,
  input  logic             clr,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out0_valid,
  output logic             out1_valid,
  input  logic             out0_ready,
  input  logic             out1_ready,
  output logic [WIDTH-1:0] out0_data,
  output logic [WIDTH-1:0] out1_data,
  output logic [CNT_W-1:0] cnt0,
  output logic [CNT_W-1:0] cnt1,
  output logic             rr_ptr
);

  logic target;
  logic can0, can1;
  logic accept;
  logic load0, load1;

  // NOTE: every signal assigned in always_comb gets a default first so no
  // latch is inferred, including for the reserved mode encoding.
  always_comb begin
    target = sel;
    unique case (mode_e'(mode))
      MODE_FIXED: target = sel;
      MODE_RR:    target = rr_ptr;
      MODE_FILL:  target = ~can0;
      default:    target = sel;
    endcase
  end

  // in_ready never looks at in_valid, keeping the handshake loop-free.
  assign in_ready = target ? can1 : can0;
  assign accept   = in_valid & in_ready;
  assign load0    = accept & ~target;
  assign load1    = accept &  target;

  dmux_disp_slot #(.WIDTH(WIDTH)) u_slot0 (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (load0),
    .load_data  (in_data),
    .out_ready  (out0_ready),
    .out_valid  (out0_valid),
    .out_data   (out0_data),
    .can_accept (can0)
  );

  dmux_disp_slot #(.WIDTH(WIDTH)) u_slot1 (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (load1),
    .load_data  (in_data),
    .out_ready  (out1_ready),
    .out_valid  (out1_valid),
    .out_data   (out1_data),
    .can_accept (can1)
  );

  // clr outranks an accept for bookkeeping; the word itself still lands.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt0   <= '0;
      cnt1   <= '0;
      rr_ptr <= 1'b0;
    end else if (clr) begin
      cnt0   <= '0;
      cnt1   <= '0;
      rr_ptr <= 1'b0;
    end else begin
      if (load0) cnt0 <= cnt0 + CNT_W'(1);
      if (load1) cnt1 <= cnt1 + CNT_W'(1);
      if (accept && mode_e'(mode) == MODE_RR) rr_ptr <= ~rr_ptr;
    end
  end

endmodule : dmux_1by2_dispatcher

// File: tb/tb_dmux_1by2_dispatcher.sv
// Bench for dmux_1by2_dispatcher: directed scenarios plus randomized traffic
// compared against a channel-array reference model.
module tb_dmux_1by2_dispatcher;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] mode = 2'd0;
  logic       sel = 1'b0;
  logic       clr = 1'b0;
  logic       in_valid = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       out0_ready = 1'b0;
  logic       out1_ready = 1'b0;

  logic        in_ready, out0_valid, out1_valid, rr_ptr;
  logic [7:0]  out0_data, out1_data;
  logic [15:0] cnt0, cnt1;

  logic        s_in_ready, s_out0_valid, s_out1_valid, s_rr_ptr;
  logic [7:0]  s_out0_data, s_out1_data;
  logic [1:0]  s_cnt0, s_cnt1;

  int checks = 0;
  int passed = 0;

  always #5 clk = ~clk;

  dmux_1by2_dispatcher #(.WIDTH(8), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .mode(mode), .sel(sel), .clr(clr),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out0_valid(out0_valid), .out1_valid(out1_valid),
    .out0_ready(out0_ready), .out1_ready(out1_ready),
    .out0_data(out0_data), .out1_data(out1_data),
    .cnt0(cnt0), .cnt1(cnt1), .rr_ptr(rr_ptr)
  );

  dmux_1by2_dispatcher #(.WIDTH(8), .CNT_W(2)) dut_small (
    .clk(clk), .rst_n(rst_n), .mode(mode), .sel(sel), .clr(clr),
    .in_valid(in_valid), .in_ready(s_in_ready), .in_data(in_data),
    .out0_valid(s_out0_valid), .out1_valid(s_out1_valid),
    .out0_ready(out0_ready), .out1_ready(out1_ready),
    .out0_data(s_out0_data), .out1_data(s_out1_data),
    .cnt0(s_cnt0), .cnt1(s_cnt1), .rr_ptr(s_rr_ptr)
  );

  // Reference model: what each channel holds, how many words each got.
  bit          mv[2];
  logic [7:0]  md[2];
  int unsigned mcnt[2];
  bit          mrr;
  logic        exp_ready, obs_ready;

  function automatic bit m_can(int k);
    bit rdy = (k == 0) ? out0_ready : out1_ready;
    return !mv[k] || rdy;
  endfunction

  function automatic int m_tgt();
    case (mode)
      2'd1:    return int'(mrr);
      2'd2:    return m_can(0) ? 0 : 1;
      default: return int'(sel);
    endcase
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      mv[k] = 1'b0; md[k] = 8'h00; mcnt[k] = 0;
    end
    mrr = 1'b0;
  endtask

  // Advance one clock: sample in_ready mid-cycle, update model at the edge.
  task automatic tick();
    int t;
    bit acc;
    bit rdy[2];
    @(negedge clk);
    t = m_tgt();
    exp_ready = m_can(t);
    obs_ready = in_ready;
    acc = in_valid && exp_ready;
    rdy[0] = out0_ready; rdy[1] = out1_ready;
    @(posedge clk);
    for (int k = 0; k < 2; k++) begin
      if (acc && t == k) begin
        mv[k] = 1'b1; md[k] = in_data;
      end else if (mv[k] && rdy[k]) begin
        mv[k] = 1'b0;
      end
    end
    if (clr) begin
      mcnt[0] = 0; mcnt[1] = 0; mrr = 1'b0;
    end else if (acc) begin
      mcnt[t] = mcnt[t] + 1;
      if (mode == 2'd1) mrr = ~mrr;
    end
    #1;
  endtask

  task automatic clear_tick();
    in_valid = 1'b0; out0_ready = 1'b1; out1_ready = 1'b1; clr = 1'b1;
    tick();
    clr = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    checks++;
    if ({out0_valid, out1_valid, out0_data, out1_data, cnt0, cnt1, rr_ptr} !== 51'd0)
      $display("FAIL reset_state got v=%b%b d=%h/%h c=%h/%h rr=%b want all 0",
               out0_valid, out1_valid, out0_data, out1_data, cnt0, cnt1, rr_ptr);
    else passed++;
    @(negedge clk); rst_n = 1'b1;
    model_reset();
    checks++;
    if (in_ready !== 1'b1) $display("FAIL reset_in_ready got %b want 1", in_ready);
    else passed++;
    // Hold a word in ch0, then reset mid-transfer between edges.
    mode = 2'd0; sel = 1'b0; out0_ready = 1'b0; in_valid = 1'b1; in_data = 8'hC3;
    tick();
    in_valid = 1'b0;
    checks++;
    if (out0_valid !== 1'b1 || out0_data !== 8'hC3)
      $display("FAIL reset_preload got %b/%h want 1/c3", out0_valid, out0_data);
    else passed++;
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({out0_valid, out1_valid, out0_data, out1_data, cnt0, cnt1, rr_ptr} !== 51'd0)
      $display("FAIL reset_async got v=%b d=%h c=%h want 0/00/0000",
               out0_valid, out0_data, cnt0);
    else passed++;
    model_reset();
    @(negedge clk); rst_n = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1) $display("FAIL reset_release_ready got %b want 1", in_ready);
    else passed++;
  endtask

  task automatic test_fixed();
    logic [7:0] words[3] = '{8'h11, 8'h22, 8'h33};
    clear_tick();
    mode = 2'd0; sel = 1'b1; out0_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_data = words[i];
      tick();
      checks++;
      if (obs_ready !== 1'b1 || out1_valid !== 1'b1 || out1_data !== words[i] || out0_valid !== 1'b0)
        $display("FAIL fixed_word%0d got rdy=%b v1=%b d1=%h v0=%b want 1/1/%h/0",
                 i, obs_ready, out1_valid, out1_data, out0_valid, words[i]);
      else passed++;
    end
    in_valid = 1'b0;
    checks++;
    if (cnt1 !== 16'd3 || cnt0 !== 16'd0)
      $display("FAIL fixed_counts got %0d/%0d want 0/3", cnt0, cnt1);
    else passed++;
  endtask

  task automatic test_rr();
    clear_tick();
    mode = 2'd1;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_data = 8'hA0 + 8'(i);
      tick();
      checks++;
      if (i % 2 == 0 ? (out0_data !== in_data || out0_valid !== 1'b1)
                     : (out1_data !== in_data || out1_valid !== 1'b1))
        $display("FAIL rr_route%0d got d0=%h d1=%h want %h on ch%0d",
                 i, out0_data, out1_data, in_data, i % 2);
      else passed++;
    end
    in_valid = 1'b0;
    checks++;
    if (rr_ptr !== 1'b0) $display("FAIL rr_ptr_wrap got %b want 0", rr_ptr);
    else passed++;
    // Stalled ch1: the fourth word must wait, not skip to ch0.
    clear_tick();
    out1_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_data = 8'hA0 + 8'(i);
      tick();
    end
    in_data = 8'hA3;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (obs_ready !== 1'b0 || rr_ptr !== 1'b1 || out1_data !== 8'hA1)
        $display("FAIL rr_stall%0d got rdy=%b rr=%b d1=%h want 0/1/a1",
                 i, obs_ready, rr_ptr, out1_data);
      else passed++;
    end
    out1_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    checks++;
    if (obs_ready !== 1'b1 || out1_data !== 8'hA3 || rr_ptr !== 1'b0)
      $display("FAIL rr_release got rdy=%b d1=%h rr=%b want 1/a3/0",
               obs_ready, out1_data, rr_ptr);
    else passed++;
  endtask

  task automatic test_fill();
    clear_tick();
    mode = 2'd2; out0_ready = 1'b0;
    in_valid = 1'b1; in_data = 8'hF0;
    tick();
    checks++;
    if (out0_valid !== 1'b1 || out0_data !== 8'hF0)
      $display("FAIL fill_first got %b/%h want 1/f0", out0_valid, out0_data);
    else passed++;
    for (int i = 1; i < 3; i++) begin
      in_data = 8'hF0 + 8'(i);
      tick();
      checks++;
      if (out1_data !== in_data || out0_data !== 8'hF0)
        $display("FAIL fill_spill%0d got d0=%h d1=%h want f0/%h", i, out0_data, out1_data, in_data);
      else passed++;
    end
    out0_ready = 1'b1; in_data = 8'hF3;
    tick();
    in_valid = 1'b0;
    checks++;
    if (obs_ready !== 1'b1 || out0_data !== 8'hF3 || cnt0 !== 16'd2 || cnt1 !== 16'd2)
      $display("FAIL fill_return got rdy=%b d0=%h c=%0d/%0d want 1/f3/2/2",
               obs_ready, out0_data, cnt0, cnt1);
    else passed++;
  endtask

  task automatic test_wrap();
    logic [1:0] seq[5] = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
    clear_tick();
    mode = 2'd0; sel = 1'b0;
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; in_data = 8'h40 + 8'(i);
      tick();
      checks++;
      if (s_cnt0 !== seq[i]) $display("FAIL wrap_cnt%0d got %0d want %0d", i, s_cnt0, seq[i]);
      else passed++;
    end
    clr = 1'b1; in_data = 8'h5A;
    tick();
    clr = 1'b0; in_valid = 1'b0;
    checks++;
    if (s_cnt0 !== 2'd0 || cnt0 !== 16'd0 || out0_valid !== 1'b1 || out0_data !== 8'h5A)
      $display("FAIL clr_with_accept got c=%0d/%0d v=%b d=%h want 0/0/1/5a",
               s_cnt0, cnt0, out0_valid, out0_data);
    else passed++;
  endtask

  task automatic test_backpressure();
    clear_tick();
    mode = 2'd0; sel = 1'b0; out0_ready = 1'b0;
    in_valid = 1'b1; in_data = 8'h77;
    tick();
    for (int i = 0; i < 5; i++) begin
      in_data = 8'h80 + 8'(i);
      tick();
      checks++;
      if (obs_ready !== 1'b0 || out0_data !== 8'h77 || out0_valid !== 1'b1 || cnt0 !== 16'd1)
        $display("FAIL hold%0d got rdy=%b d0=%h v0=%b c0=%0d want 0/77/1/1",
                 i, obs_ready, out0_data, out0_valid, cnt0);
      else passed++;
    end
    in_valid = 1'b0;
  endtask

  task automatic test_random();
    int bad = 0;
    for (int n = 0; n < 400; n++) begin
      mode       = 2'($urandom_range(0, 3));
      sel        = 1'($urandom_range(0, 1));
      clr        = ($urandom_range(0, 24) == 0);
      in_valid   = ($urandom_range(0, 3) != 0);
      in_data    = 8'($urandom);
      out0_ready = ($urandom_range(0, 2) != 0);
      out1_ready = ($urandom_range(0, 2) != 0);
      tick();
      checks++;
      if (obs_ready !== exp_ready ||
          {out0_valid, out1_valid, out0_data, out1_data, cnt0, cnt1, rr_ptr} !==
          {mv[0], mv[1], md[0], md[1], 16'(mcnt[0]), 16'(mcnt[1]), mrr} ||
          {s_cnt0, s_cnt1} !== {2'(mcnt[0]), 2'(mcnt[1])}) begin
        if (bad < 10)
          $display("FAIL random%0d got rdy=%b v=%b%b d=%h/%h c=%0d/%0d rr=%b want rdy=%b v=%b%b d=%h/%h c=%0d/%0d rr=%b",
                   n, obs_ready, out0_valid, out1_valid, out0_data, out1_data, cnt0, cnt1, rr_ptr,
                   exp_ready, mv[0], mv[1], md[0], md[1], 16'(mcnt[0]), 16'(mcnt[1]), mrr);
        bad++;
      end else passed++;
    end
    clr = 1'b0; in_valid = 1'b0;
  endtask

  initial begin
    model_reset();
    test_reset();
    test_fixed();
    test_rr();
    test_fill();
    test_wrap();
    test_backpressure();
    test_random();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule : tb_dmux_1by2_dispatcher
